store_rmw_ctrl: RTL and testbench

//  Sequences sub-word stores (SB/SH) against a word-wide data memory as a read-modify-write.

---
 rtl/store_rmw_ctrl.sv | 172 +++++++++++++++++
 tb/tb_store_rmw_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: word stores are a single write; SB/SH do read, lane merge, write-back.
// Latency with zero-wait memory: word 3 cycles, sub-word 5; st_ready low while busy.
// Optional MISALIGN_TRAP_EN: misaligned SH/word stores complete with st_err and no memory access.
module store_rmw_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_data,
    input  logic              i_sb,
    input  logic              i_sh,
    output logic              o_st_done,
    output logic              o_st_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_lane;
    logic              r_byte;
    logic [15:0]       r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_st_done;
    logic              r_st_err;

    logic              w_accept;
    logic              w_is_byte;
    logic              w_is_sub;
    logic              w_misalign;
    logic              w_timeout;
    logic [31:0]       w_merged;

    assign w_accept  = i_st_valid && (r_state == S_IDLE);
    assign w_is_byte = i_sb;
    assign w_is_sub  = i_sb || i_sh;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (!i_sb && i_sh && i_st_addr[0]) ||
                        (!w_is_sub && (i_st_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Ack in the final allowed cycle still counts as success.
    assign w_timeout = r_mem_req && !i_mem_ack && (r_cnt == CNT_LAST);

    always_comb begin
        w_merged = i_mem_rdata;
        if (r_byte) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_data;
        end else begin
            w_merged[15:0] = r_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_lane      <= 2'b00;
            r_byte      <= 1'b0;
            r_data      <= 16'h0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_st_done   <= 1'b0;
            r_st_err    <= 1'b0;
        end else begin
            r_st_done <= 1'b0;
            r_st_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_addr <= {i_st_addr[ADDR_W-1:2], 2'b00};
                        r_lane     <= i_st_addr[1:0];
                        r_byte     <= w_is_byte;
                        r_data     <= i_st_data[15:0];
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_is_sub) begin
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_state   <= S_RD;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= i_st_data;
                            r_state     <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (i_mem_ack) begin
                        // Drop the request for one cycle so the write is a fresh access.
                        r_mem_wdata <= w_merged;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_WR;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_st_done <= 1'b1;
                    r_st_err  <= r_err;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_st_ready  = (r_state == S_IDLE);
    assign o_st_done   = r_st_done;
    assign o_st_err    = r_st_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: behavioural memory with programmable ack latency,
// directed cases then random stores checked against a lane-merge reference.
module tb_store_rmw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        sb;
    logic        sh;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.ADDR_W(32), .ACK_TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_st_valid  (st_valid),
        .o_st_ready  (st_ready),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .i_sb        (sb),
        .i_sh        (sh),
        .o_st_done   (st_done),
        .o_st_err    (st_err),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    // Memory: ack arrives after 'lat' extra request cycles (lat=0 acks in the first one).
    logic [31:0] tbmem   [0:1023];
    logic [31:0] exp_mem [0:1023];
    logic        mem_init;
    logic        pl_vld;
    logic [9:0]  pl_idx;
    logic [31:0] pl_dat;
    int          lat;
    int          wait_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tbmem[i] <= init_word(i);
        end else if (pl_vld) begin
            tbmem[pl_idx] <= pl_dat;
        end else if (mem_req && mem_ack && mem_we) begin
            tbmem[mem_addr[11:2]] <= mem_wdata;
        end
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    assign mem_ack   = mem_req && (wait_cnt == lat);
    assign mem_rdata = tbmem[mem_addr[11:2]];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_vld = 1'b1;
        pl_idx = a[11:2];
        pl_dat = v;
        @(negedge clk);
        pl_vld = 1'b0;
        exp_mem[a[11:2]] = v;
    endtask

    int          res_cyc;
    logic        res_err;
    int          res_rd;
    int          res_wr;
    int          res_maxrun;
    logic        res_busy;
    logic [31:0] res_wa;
    logic [31:0] res_ra;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic b, input logic h, input int l);
        int run;
        @(negedge clk);
        lat = l;
        st_addr = a; st_data = d; sb = b; sh = h; st_valid = 1'b1;
        @(posedge clk);
        #1;
        st_valid = 1'b0; sb = 1'b0; sh = 1'b0;
        res_cyc = 0; res_err = 1'b0; res_rd = 0; res_wr = 0; res_maxrun = 0;
        res_busy = 1'b1; res_wa = 32'hFFFFFFFF; res_ra = 32'hFFFFFFFF;
        run = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (mem_req) begin
                run++;
                if (run > res_maxrun) res_maxrun = run;
            end else begin
                run = 0;
            end
            if (mem_req && mem_ack) begin
                if (mem_we) begin res_wr++; res_wa = mem_addr; end
                else        begin res_rd++; res_ra = mem_addr; end
            end
            if (k == 1) res_busy = st_ready;
            if (st_done) begin
                res_cyc = k;
                res_err = st_err;
                break;
            end
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic b, input logic h);
        int sh_amt;
        if (b) begin
            sh_amt = 8 * int'(a[1:0]);
            return (old & ~(32'h000000FF << sh_amt)) | ((d & 32'h000000FF) << sh_amt);
        end else if (h) begin
            sh_amt = 16 * int'(a[1]);
            return (old & ~(32'h0000FFFF << sh_amt)) | ((d & 32'h0000FFFF) << sh_amt);
        end
        return d;
    endfunction

    function automatic logic ref_trap(input logic [31:0] a, input logic b, input logic h);
`ifdef MISALIGN_TRAP_EN
        if (b) return 1'b0;
        if (h) return a[0];
        return a[1:0] != 2'b00;
`else
        return 1'b0 & a[0] & b & h;
`endif
    endfunction

    task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                                 input logic b, input logic h, input int l);
        logic       trap, tmo, sub;
        logic [9:0] idx;
        int         e_cyc, e_rd, e_wr, e_run;
        idx  = a[11:2];
        trap = ref_trap(a, b, h);
        tmo  = (l >= 16);
        sub  = b | h;
        e_cyc = trap ? 2 : tmo ? 18 : sub ? 5 + 2 * l : 3 + l;
        e_rd  = (!trap && sub && !tmo) ? 1 : 0;
        e_wr  = (!trap && !tmo) ? 1 : 0;
        e_run = trap ? 0 : tmo ? 16 : l + 1;
        if (e_wr == 1) exp_mem[idx] = ref_merge(exp_mem[idx], a, d, b, h);
        do_store(a, d, b, h, l);
        check({tag, ".latency"}, 64'(res_cyc), 64'(e_cyc));
        check({tag, ".err"},     64'(res_err), 64'(trap | tmo));
        check({tag, ".reads"},   64'(res_rd),  64'(e_rd));
        check({tag, ".writes"},  64'(res_wr),  64'(e_wr));
        check({tag, ".req_run"}, 64'(res_maxrun), 64'(e_run));
        check({tag, ".busy"},    64'(res_busy), 64'(0));
        check({tag, ".word"},    64'(tbmem[idx]), 64'(exp_mem[idx]));
        if (e_wr == 1) check({tag, ".waddr"}, 64'(res_wa), 64'({a[31:2], 2'b00}));
        if (e_rd == 1) check({tag, ".raddr"}, 64'(res_ra), 64'({a[31:2], 2'b00}));
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; mem_init = 1'b1; pl_vld = 1'b0; pl_idx = 10'd0; pl_dat = 32'h0;
        lat = 0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; sb = 1'b0; sh = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst.st_ready",  64'(st_ready),  64'(1));
        check("rst.mem_req",   64'(mem_req),   64'(0));
        check("rst.mem_we",    64'(mem_we),    64'(0));
        check("rst.mem_addr",  64'(mem_addr),  64'(0));
        check("rst.mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst.st_done",   64'(st_done),   64'(0));
        check("rst.st_err",    64'(st_err),    64'(0));

        run_and_check("t1_word", 32'h00000104, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        check("t1.value", 64'(tbmem[10'h041]), 64'(32'hDEADBEEF));

        preload(32'h200, 32'h11223344);
        run_and_check("t2_sb", 32'h00000203, 32'h000000AA, 1'b1, 1'b0, 0);
        check("t2.value", 64'(tbmem[10'h080]), 64'(32'hAA223344));

        preload(32'h200, 32'h11223344);
        run_and_check("t3_sh", 32'h00000202, 32'h0000BEEF, 1'b0, 1'b1, 0);
        check("t3.value", 64'(tbmem[10'h080]), 64'(32'hBEEF3344));
        preload(32'h200, 32'h11223344);
        run_and_check("t3_sbsh", 32'h00000201, 32'h00000055, 1'b1, 1'b1, 0);
        check("t3b.value", 64'(tbmem[10'h080]), 64'(32'h11225544));

        run_and_check("t4_to_wr", 32'h00000108, 32'h12345678, 1'b0, 1'b0, 1000);
        run_and_check("t4_to_rd", 32'h0000010D, 32'h000000EE, 1'b1, 1'b0, 1000);
        run_and_check("t4_ack16", 32'h00000110, 32'hCAFEF00D, 1'b0, 1'b0, 15);
        run_and_check("t4_lat2",  32'h00000116, 32'h00009876, 1'b0, 1'b1, 2);

        // Reset while a write is stalled waiting for ack.
        @(negedge clk);
        lat = 1000;
        st_addr = 32'h120; st_data = 32'h0BADF00D; st_valid = 1'b1;
        @(posedge clk);
        #1 st_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t5.req_before", 64'(mem_req), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("t5.req_after",   64'(mem_req),  64'(0));
        check("t5.ready_after", 64'(st_ready), 64'(1));
        reset = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (st_done) done_seen++;
        end
        check("t5.no_done", 64'(done_seen), 64'(0));
        check("t5.no_write", 64'(tbmem[10'h048]), 64'(exp_mem[10'h048]));

        preload(32'h200, 32'h11223344);
        run_and_check("t6_sh_odd", 32'h00000201, 32'h0000CAFE, 1'b0, 1'b1, 0);
`ifdef MISALIGN_TRAP_EN
        check("t6.value", 64'(tbmem[10'h080]), 64'(32'h11223344));
`else
        check("t6.value", 64'(tbmem[10'h080]), 64'(32'h1122CAFE));
`endif
        run_and_check("t6_word_odd", 32'h00000207, 32'h76543210, 1'b0, 1'b0, 1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rdat;
            logic        rb, rh;
            int          rl;
            ra   = 32'h300 + 32'($urandom_range(0, 63));
            rdat = $urandom;
            rb   = 1'($urandom_range(0, 1));
            rh   = 1'($urandom_range(0, 1));
            rl   = (n % 13 == 12) ? 1000 : int'($urandom_range(0, 3));
            run_and_check($sformatf("rnd%0d", n), ra, rdat, rb, rh, rl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
